// File: rtl/clk_rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM states, the per-domain
// reset bundle and the state-to-output decode.
package clk_rst_seq_pkg;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefLockCycles  = 1024;
  localparam int unsigned DefStageGap    = 16;
  localparam int unsigned DefSwrstCycles = 32;

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StStable,
    StRelDbg,
    StRelSys,
    StRelPeriph,
    StRun,
    StSwrst
  } state_e;

  typedef struct packed {
    logic dbg_nrst;
    logic sys_nrst;
    logic periph_nrst;
    logic ready;
  } rst_out_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Ready tracks the peripheral release: it is the last domain to leave reset.
  // Debug stays released through a software reset.
  function automatic rst_out_t state_outputs(input state_e st);
    rst_out_t o;
    o = '0;
    case (st)
      StRelDbg, StSwrst: o.dbg_nrst = 1'b1;
      StRelSys: begin
        o.dbg_nrst = 1'b1;
        o.sys_nrst = 1'b1;
      end
      StRelPeriph, StRun: o = '1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous active-low clear.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: qualifies PLL lock, then releases debug, system and peripheral
// resets in order; re-applies them on lock loss or a software reset request.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned LOCK_CYCLES  = DefLockCycles,
  parameter int unsigned STAGE_GAP    = DefStageGap,
  parameter int unsigned SWRST_CYCLES = DefSwrstCycles
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_pll_locked,
  input  logic i_swrst_req,
  output logic o_dbg_nrst,
  output logic o_sys_nrst,
  output logic o_periph_nrst,
  output logic o_ready
);

  localparam int unsigned CntMax = max3(LOCK_CYCLES, STAGE_GAP, SWRST_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0] SwLast   = CntW'(SWRST_CYCLES - 1);

  logic lock_s;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (i_clk),
    .rst_ni(i_nrst),
    .d_i   (i_pll_locked),
    .q_o   (lock_s)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rst_out_t        out_q;
  logic            restart;
  logic            count_en;

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    count_en = 1'b0;
    unique case (state_q)
      StHold: state_d = StWaitLock;
      StWaitLock: begin
        if (lock_s) state_d = StStable;
      end
      StStable: begin
        count_en = 1'b1;
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == LockLast) state_d = StRelDbg;
      end
      StRelDbg: begin
        count_en = 1'b1;
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == GapLast) state_d = StRelSys;
      end
      StRelSys: begin
        count_en = 1'b1;
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == GapLast) state_d = StRelPeriph;
      end
      StRelPeriph: begin
        count_en = 1'b1;
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == GapLast) state_d = StRun;
      end
      StRun: begin
        if (!lock_s) state_d = StWaitLock;
        else if (i_swrst_req) state_d = StSwrst;
      end
      StSwrst: begin
        count_en = 1'b1;
        // Lock loss wins over a new request; a new request re-arms the full pulse.
        if (!lock_s) state_d = StWaitLock;
        else if (i_swrst_req) restart = 1'b1;
        else if (cnt_q == SwLast) state_d = StRelSys;
      end
      default: state_d = StHold;
    endcase
  end

  // Shared counter: cleared on any transition, stops at its compare so never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || restart) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= StHold;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign o_dbg_nrst    = out_q.dbg_nrst;
  assign o_sys_nrst    = out_q.sys_nrst;
  assign o_periph_nrst = out_q.periph_nrst;
  assign o_ready       = out_q.ready;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: run-length/timestamp model checked every cycle, plus
// directed release-edge expectations.
module tb_clk_rst_seq;

  localparam int SyncStages  = 2;
  localparam int LockCycles  = 8;
  localparam int StageGap    = 4;
  localparam int SwrstCycles = 5;

  // Release thresholds expressed as consecutive qualified-lock edges.
  localparam int DbgAt = LockCycles + 1;
  localparam int SysAt = DbgAt + StageGap;
  localparam int PerAt = SysAt + StageGap;
  localparam int RunAt = PerAt + StageGap;
  localparam int Cap   = 1000000;

  logic clk = 1'b0;
  logic nrst, pll, swrst;
  logic dbg, sys, per, rdy;

  always #5 clk = ~clk;

  clk_rst_seq #(
    .SYNC_STAGES (SyncStages),
    .LOCK_CYCLES (LockCycles),
    .STAGE_GAP   (StageGap),
    .SWRST_CYCLES(SwrstCycles)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_pll_locked (pll),
    .i_swrst_req  (swrst),
    .o_dbg_nrst   (dbg),
    .o_sys_nrst   (sys),
    .o_periph_nrst(per),
    .o_ready      (rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_run counts consecutive edges that saw a qualified lock; m_k counts
  // edges since the last accepted software reset.
  bit       m_valid = 1'b0;
  bit       m_hold  = 1'b1;
  int       m_run   = 0;
  bit       m_sw    = 1'b0;
  int       m_k     = 0;
  bit       m_hist[SyncStages];
  logic [3:0] m_exp = '0;

  always @(posedge clk) begin : model
    bit seen;
    bit in_run;
    bit in_swrst;
    if (!nrst) begin
      m_hold = 1'b1;
      m_run  = 0;
      m_sw   = 1'b0;
      m_k    = 0;
      for (int i = 0; i < SyncStages; i++) m_hist[i] = 1'b0;
    end else begin
      seen = m_hist[SyncStages-1];
      for (int i = SyncStages - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pll;
      if (m_hold) begin
        m_hold = 1'b0;
      end else if (!seen) begin
        m_run = 0;
        m_sw  = 1'b0;
        m_k   = 0;
      end else begin
        in_run   = m_sw ? (m_k >= SwrstCycles + 2 * StageGap) : (m_run >= RunAt);
        in_swrst = m_sw && (m_k < SwrstCycles);
        if (m_run < Cap) m_run++;
        if (swrst && (in_run || in_swrst)) begin
          m_sw = 1'b1;
          m_k  = 0;
        end else if (m_sw && m_k < Cap) begin
          m_k++;
        end
      end
    end
    m_exp[3] = (m_run >= DbgAt);
    if (m_sw) begin
      m_exp[2] = (m_k >= SwrstCycles);
      m_exp[1] = (m_k >= SwrstCycles + StageGap);
    end else begin
      m_exp[2] = (m_run >= SysAt);
      m_exp[1] = (m_run >= PerAt);
    end
    m_exp[0] = m_exp[1];
    m_valid  = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if ({dbg, sys, per, rdy} !== m_exp) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t dut{dbg,sys,per,rdy}=%b model=%b", $time,
                 {dbg, sys, per, rdy}, m_exp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ticks n edges; reports the edge index (1-based) of each output's first rise, -1 if none.
  task automatic measure(input int n, output int r_dbg, output int r_sys, output int r_per,
                         output int r_rdy);
    logic [3:0] prev, cur;
    r_dbg = -1;
    r_sys = -1;
    r_per = -1;
    r_rdy = -1;
    prev  = {dbg, sys, per, rdy};
    for (int i = 1; i <= n; i++) begin
      tick(1);
      cur = {dbg, sys, per, rdy};
      if (cur[3] && !prev[3] && r_dbg < 0) r_dbg = i;
      if (cur[2] && !prev[2] && r_sys < 0) r_sys = i;
      if (cur[1] && !prev[1] && r_per < 0) r_per = i;
      if (cur[0] && !prev[0] && r_rdy < 0) r_rdy = i;
      prev = cur;
    end
  endtask

  initial begin : stim
    int rd, rs, rp, rr;
    nrst  = 1'b0;
    pll   = 1'b0;
    swrst = 1'b0;

    // Reset state
    tick(3);
    check("reset_outputs", int'({dbg, sys, per, rdy}), 0);

    // Power-up: lock driven after edge 0
    nrst = 1'b1;
    tick(1);
    pll = 1'b1;
    measure(25, rd, rs, rp, rr);
    check("pwr_dbg_edge", rd, 11);
    check("pwr_sys_edge", rs, 15);
    check("pwr_per_edge", rp, 19);
    check("pwr_rdy_edge", rr, 19);

    // Software reset from RUN
    swrst = 1'b1;
    tick(1);
    swrst = 1'b0;
    check("swrst_sys_low", int'(sys), 0);
    check("swrst_rdy_low", int'(rdy), 0);
    check("swrst_dbg_kept", int'(dbg), 1);
    measure(11, rd, rs, rp, rr);
    check("swrst_dbg_no_edge", rd, -1);
    check("swrst_sys_edge", rs, 5);
    check("swrst_per_edge", rp, 9);
    check("swrst_rdy_edge", rr, 9);
    tick(3);

    // Repeated requests every 3 cycles during SWRST
    for (int p = 0; p < 4; p++) begin
      swrst = 1'b1;
      tick(1);
      swrst = 1'b0;
      tick(2);
    end
    tick(2);
    check("rep_sys_still_low", int'(sys), 0);
    tick(1);
    check("rep_sys_released", int'(sys), 1);
    tick(10);

    // Lock loss in RUN with a simultaneous software request
    pll = 1'b0;
    tick(2);
    check("loss_pre_rdy", int'(rdy), 1);
    swrst = 1'b1;
    tick(1);
    swrst = 1'b0;
    check("loss_all_low", int'({dbg, sys, per, rdy}), 0);
    pll = 1'b1;
    measure(25, rd, rs, rp, rr);
    check("relock_dbg_edge", rd, 11);
    check("relock_rdy_edge", rr, 19);

    // Unstable lock: 5 high, 1 low, then high
    pll = 1'b0;
    tick(4);
    check("unstable_pre_low", int'({dbg, sys, per, rdy}), 0);
    pll = 1'b1;
    tick(5);
    pll = 1'b0;
    tick(1);
    pll = 1'b1;
    measure(20, rd, rs, rp, rr);
    check("unstable_dbg_edge", rd, 11);
    check("unstable_sys_edge", rs, 15);
    check("unstable_per_edge", rp, 19);

    // Reset mid-sequence while in REL_SYS (lock already high at release)
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(1);
    measure(16, rd, rs, rp, rr);
    check("mid_dbg_edge", rd, 10);
    check("mid_sys_edge", rs, 14);
    check("mid_in_rel_sys", int'({dbg, sys, per, rdy}), 4'b1100);
    nrst = 1'b0;
    tick(1);
    check("mid_reset_low", int'({dbg, sys, per, rdy}), 0);
    // A request while leaving HOLD must be ignored
    nrst  = 1'b1;
    swrst = 1'b1;
    tick(1);
    swrst = 1'b0;
    measure(20, rd, rs, rp, rr);
    check("restart_dbg_edge", rd, 10);
    check("restart_sys_edge", rs, 14);
    check("restart_per_edge", rp, 18);
    check("restart_rdy_edge", rr, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
